pipeline_hazard_ctrl: RTL and testbench

Central sequencing controller for the five-stage rv32i pipeline datapath. Each cycle it generates the PC load, PC mux select, the four inter-stage register load enables and bubble-insert (flush) controls from cache handshakes, execute-stage branch resolution and decode/execute register dependences. It also keeps stall and flush performance counters. It sits beside the datapath in the CPU top and replaces ad-hoc load-enable logic.

---
 rtl/pipeline_hazard_ctrl.sv | 85 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: pipeline load/flush/PC sequencing with stall and redirect counters
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_read,
  input  logic             icache_resp,
  input  logic             dmem_req,
  input  logic             dcache_resp,
  input  logic             exe_valid,
  input  logic             exe_is_br,
  input  logic             exe_is_jal,
  input  logic             exe_is_jalr,
  input  logic             br_en,
  input  logic             exe_is_load,
  input  logic [4:0]       exe_rd,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  output logic             load_pc,
  output logic [1:0]       pcmux_sel,
  output logic             fet_dec_load,
  output logic             dec_exe_load,
  output logic             exe_mem_load,
  output logic             mem_wb_load,
  output logic             fet_dec_flush,
  output logic             dec_exe_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  localparam logic [1:0] INIT = 2'd0, RUN = 2'd1, MEM_WAIT = 2'd2;
  logic [1:0] state, state_n;
  logic in_init, miss, redirect, hazard, take_redirect;
  assign in_init = ~rst | (state == INIT);
  assign miss = (imem_read & ~icache_resp) | (dmem_req & ~dcache_resp);
  assign redirect = exe_valid & (exe_is_jal | exe_is_jalr | (exe_is_br & br_en));
  assign hazard = exe_valid & exe_is_load & (exe_rd != 5'd0) & dec_valid &
                  ((dec_use_rs1 & (dec_rs1 == exe_rd)) | (dec_use_rs2 & (dec_rs2 == exe_rd)));
  assign take_redirect = ~in_init & ~miss & redirect;
  // Priority: init bubbles, miss freeze, redirect, load-use bubble, normal advance
  always_comb begin
    load_pc = 1'b1;
    pcmux_sel = 2'd0;
    fet_dec_load = 1'b1;
    dec_exe_load = 1'b1;
    exe_mem_load = 1'b1;
    mem_wb_load = 1'b1;
    fet_dec_flush = 1'b0;
    dec_exe_flush = 1'b0;
    state_n = RUN;
    if (in_init || miss) begin
      load_pc = 1'b0;
      fet_dec_load = 1'b0;
      dec_exe_load = 1'b0;
      exe_mem_load = 1'b0;
      mem_wb_load = 1'b0;
      fet_dec_flush = in_init;
      dec_exe_flush = in_init;
      state_n = in_init ? RUN : MEM_WAIT;
    end else if (redirect) begin
      pcmux_sel = exe_is_jalr ? 2'd2 : 2'd1;
      fet_dec_flush = 1'b1;
      dec_exe_flush = 1'b1;
    end else if (hazard) begin
      load_pc = 1'b0;
      fet_dec_load = 1'b0;
      dec_exe_flush = 1'b1;
    end
  end
  // State register and saturating stall/redirect counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT;
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      state <= state_n;
      if (!in_init && !load_pc && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      if (take_redirect && !(&flush_count)) flush_count <= flush_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for pipeline_hazard_ctrl with 4-bit counters
module tb_pipeline_hazard_ctrl;
  typedef struct packed {
    logic rst, imem_read, icache_resp, dmem_req, dcache_resp;
    logic exe_valid, exe_is_br, exe_is_jal, exe_is_jalr, br_en, exe_is_load;
    logic [4:0] exe_rd;
    logic dec_valid;
    logic [4:0] dec_rs1, dec_rs2;
    logic dec_use_rs1, dec_use_rs2;
  } stim_t;
  typedef struct packed {
    logic [8:0] ctl;
    logic [3:0] stall, flush;
    logic cnt_ok;
  } exp_t;
  localparam logic [8:0] C_INIT = 9'b0_00_0000_11;
  localparam logic [8:0] C_NORM = 9'b1_00_1111_00;
  localparam logic [8:0] C_MISS = 9'b0_00_0000_00;
  localparam logic [8:0] C_JALR = 9'b1_10_1111_11;
  localparam logic [8:0] C_BR   = 9'b1_01_1111_11;
  localparam logic [8:0] C_HAZ  = 9'b0_00_0111_01;
  logic clk = 1'b0;
  stim_t s = '0;
  logic load_pc, fet_dec_load, dec_exe_load, exe_mem_load, mem_wb_load, fet_dec_flush, dec_exe_flush;
  logic [1:0] pcmux_sel;
  logic [3:0] stall_cycles, flush_count;
  exp_t q[$];
  string tq[$];
  int n_chk = 0, n_pass = 0;
  logic [3:0] m_stall = '0, m_flush = '0;
  logic m_init = 1'b1, cnt_known = 1'b0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst(s.rst), .imem_read(s.imem_read), .icache_resp(s.icache_resp),
    .dmem_req(s.dmem_req), .dcache_resp(s.dcache_resp), .exe_valid(s.exe_valid),
    .exe_is_br(s.exe_is_br), .exe_is_jal(s.exe_is_jal), .exe_is_jalr(s.exe_is_jalr),
    .br_en(s.br_en), .exe_is_load(s.exe_is_load), .exe_rd(s.exe_rd), .dec_valid(s.dec_valid),
    .dec_rs1(s.dec_rs1), .dec_rs2(s.dec_rs2), .dec_use_rs1(s.dec_use_rs1), .dec_use_rs2(s.dec_use_rs2),
    .load_pc(load_pc), .pcmux_sel(pcmux_sel), .fet_dec_load(fet_dec_load), .dec_exe_load(dec_exe_load),
    .exe_mem_load(exe_mem_load), .mem_wb_load(mem_wb_load), .fet_dec_flush(fet_dec_flush),
    .dec_exe_flush(dec_exe_flush), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // Drive one cycle of stimulus, queue its expectation, then advance the counter model
  task automatic cyc(input string tag, input stim_t st, input logic [8:0] ctl);
    @(posedge clk);
    #1;
    s = st;
    q.push_back('{ctl, m_stall, m_flush, cnt_known});
    tq.push_back(tag);
    if (!st.rst) begin
      m_stall = '0;
      m_flush = '0;
      m_init = 1'b1;
      cnt_known = 1'b1;
    end else begin
      if (!m_init) begin
        if (!ctl[8] && m_stall != 4'hf) m_stall++;
        if ((ctl == C_BR || ctl == C_JALR) && m_flush != 4'hf) m_flush++;
      end
      m_init = 1'b0;
    end
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      string t;
      e = q.pop_front();
      t = tq.pop_front();
      chk({t, ".ctl"}, {23'd0, load_pc, pcmux_sel, fet_dec_load, dec_exe_load, exe_mem_load,
          mem_wb_load, fet_dec_flush, dec_exe_flush}, {23'd0, e.ctl});
      if (e.cnt_ok) begin
        chk({t, ".stall"}, {28'd0, stall_cycles}, {28'd0, e.stall});
        chk({t, ".flush"}, {28'd0, flush_count}, {28'd0, e.flush});
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    stim_t v, base;
    base = '0;
    base.rst = 1'b1;
    v = '0;
    repeat (3) cyc("reset", v, C_INIT);
    v = base;
    cyc("init", v, C_INIT);
    cyc("run", v, C_NORM);
    v.dmem_req = 1'b1;
    repeat (5) cyc("dmiss", v, C_MISS);
    v.dcache_resp = 1'b1;
    cyc("dresp", v, C_NORM);
    v = base;
    cyc("idle", v, C_NORM);
    v.exe_valid = 1'b1;
    v.exe_is_jalr = 1'b1;
    cyc("jalr", v, C_JALR);
    v.exe_is_jalr = 1'b0;
    v.exe_is_br = 1'b1;
    cyc("br_nt", v, C_NORM);
    v.br_en = 1'b1;
    cyc("br_t", v, C_BR);
    v.exe_valid = 1'b0;
    cyc("br_inv", v, C_NORM);
    v = base;
    v.exe_valid = 1'b1;
    v.exe_is_jal = 1'b1;
    cyc("jal", v, C_BR);
    v = base;
    v.exe_valid = 1'b1;
    v.exe_is_load = 1'b1;
    v.exe_rd = 5'd5;
    v.dec_valid = 1'b1;
    v.dec_rs2 = 5'd5;
    v.dec_use_rs2 = 1'b1;
    cyc("lu_rs2", v, C_HAZ);
    v.exe_is_load = 1'b0;
    cyc("lu_clr", v, C_NORM);
    v.exe_is_load = 1'b1;
    v.exe_rd = 5'd0;
    v.dec_rs2 = 5'd0;
    cyc("lu_x0", v, C_NORM);
    v.exe_rd = 5'd5;
    v.dec_rs2 = 5'd5;
    v.dec_use_rs2 = 1'b0;
    cyc("lu_nouse", v, C_NORM);
    v.dec_rs1 = 5'd5;
    v.dec_use_rs1 = 1'b1;
    cyc("lu_rs1", v, C_HAZ);
    v.dec_valid = 1'b0;
    cyc("lu_decinv", v, C_NORM);
    v.dec_valid = 1'b1;
    v.exe_is_jal = 1'b1;
    cyc("lu_redir", v, C_BR);
    v = base;
    v.imem_read = 1'b1;
    v.exe_valid = 1'b1;
    v.exe_is_br = 1'b1;
    v.br_en = 1'b1;
    repeat (3) cyc("ibr_miss", v, C_MISS);
    v.icache_resp = 1'b1;
    cyc("ibr_rel", v, C_BR);
    v = base;
    v.imem_read = 1'b1;
    v.dmem_req = 1'b1;
    repeat (2) cyc("both_miss", v, C_MISS);
    v.icache_resp = 1'b1;
    cyc("d_only", v, C_MISS);
    v.dcache_resp = 1'b1;
    cyc("both_rel", v, C_NORM);
    v = base;
    v.dmem_req = 1'b1;
    repeat (20) cyc("sat", v, C_MISS);
    v.dmem_req = 1'b0;
    cyc("sat_rel", v, C_NORM);
    v.dmem_req = 1'b1;
    cyc("mid_miss", v, C_MISS);
    v.rst = 1'b0;
    cyc("rst_mid", v, C_INIT);
    v.rst = 1'b1;
    cyc("post_rst", v, C_INIT);
    v.dmem_req = 1'b0;
    cyc("post_run", v, C_NORM);
    cyc("post_idle", v, C_NORM);
    @(negedge clk);
    #1;
    if (q.size() != 0) chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
